// File: rtl/range_pkg.sv
// Purpose: shared types and sizing helpers for the range encoder and its benches.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package range_pkg;

    // Encoder control states, in visiting order.
    typedef enum logic [2:0] {
        IDLE,
        DIFF,
        SQX,
        SQY,
        SQRT,
        FIN,
        HOLD
    } re_state_e;

    localparam int DEF_N   = 8;
    localparam int H_W     = 2 * DEF_N + 1;      // squared-distance width
    localparam int ROOT_W  = DEF_N + 1;          // root / rA field width
    localparam int SAT_VAL = (1 << DEF_N) - 1;   // largest encodable radius

    function automatic int h_width(input int n);
        return 2 * n + 1;
    endfunction

    function automatic int root_width(input int n);
        return n + 1;
    endfunction

    function automatic int sat_value(input int n);
        return (1 << n) - 1;
    endfunction

    // Cycles from the accept edge to the cycle in which out_valid is first high.
    function automatic int latency(input int n);
        return 3 * n + 4;
    endfunction

endpackage

// File: rtl/isqrt_ceil_seq.sv
// Purpose: iterative restoring square root (one root bit per cycle, MSB first) with ceil rounding and clamp.
// Latency: W/2 cycles after the start edge; done_o is high during the final iteration cycle.
// Backpressure: none; results hold until the next start, a new start restarts immediately.
//
// Ports: clk, rst (sync active-high), start_i loads rad_i; done_o flags the last iteration;
//        ceil_o = ceil(sqrt(rad_i)) clamped to MAXR; sat_o set when the clamp applied.
module isqrt_ceil_seq #(
    parameter int W    = 18,
    parameter int MAXR = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [W-1:0]   rad_i,
    output logic           done_o,
    output logic [W/2-1:0] ceil_o,
    output logic           sat_o
);
    localparam int RW   = W / 2;
    localparam int REMW = RW + 3;   // remainder <= 2*root, plus two shifted-in bits
    localparam int CW   = (RW > 1) ? $clog2(RW) : 1;

    logic [W-1:0]    rad_q;
    logic [REMW-1:0] rem_q;
    logic [RW-1:0]   root_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;

    logic [REMW-1:0] rem_sh;
    logic [REMW-1:0] trial;
    logic            ge;
    logic [RW:0]     ceil_w;

    // Bring down the next two radicand bits; the trial subtrahend is 4*root+1.
    assign rem_sh = {rem_q[REMW-3:0], rad_q[W-1 -: 2]};
    assign trial  = REMW'({root_q, 2'b01});
    assign ge     = (rem_sh >= trial);

    assign done_o = busy_q && (cnt_q == CW'(RW - 1));
    assign ceil_w = {1'b0, root_q} + {{RW{1'b0}}, (|rem_q)};
    assign sat_o  = (ceil_w > (RW + 1)'(MAXR));
    assign ceil_o = sat_o ? RW'(MAXR) : ceil_w[RW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rad_q  <= rad_i;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rad_q  <= {rad_q[W-3:0], 2'b00};
            rem_q  <= ge ? (rem_sh - trial) : rem_sh;
            root_q <= {root_q[RW-2:0], ge};
            cnt_q  <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/range_encoder.sv
// Purpose: compute minimal radius rA (rA^2 >= dx^2+dy^2) and emit the {xA, yA, rA} anchor record.
// Latency: out_valid first high 3N+4 cycles after the accept edge; one record per 3N+5 cycles.
// Backpressure: record held stable in HOLD until out_ready; in_ready only while IDLE.
//
// Ports: clk, rst (sync active-high); g_input {xD,yD} and a_xy {xA,yA} taken on in_valid&in_ready;
//        e_output {xA,yA,rA}, sat (radius clamped to 2^N-1), out_valid/out_ready handshake.
// Build option: RANGE_ENCODER_DIST_OUT_EN adds dist_sq (the squared distance H), valid with out_valid.
module range_encoder
    import range_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2*N-1:0] g_input,
    input  logic [2*N-1:0] a_xy,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [3*N:0]   e_output,
    output logic           sat,
    output logic           out_valid,
    input  logic           out_ready
`ifdef RANGE_ENCODER_DIST_OUT_EN
    ,
    output logic [2*N:0]   dist_sq
`endif
);
    localparam int HW = h_width(N);
    localparam int RW = root_width(N);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    re_state_e state_q, state_d;

    logic [N-1:0]  xd_q, yd_q, xa_q, ya_q;
    logic [N-1:0]  magx_q, magy_q;
    logic [HW-1:0] h_q, h_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3*N:0]  out_q;
    logic          sat_q;

    logic [N:0]    dx, dy;
    logic [N-1:0]  mag_sel;
    logic [HW-1:0] pp;
    logic          last_bit;
    logic          accept;
    logic          sq_start, sq_done, sq_sat;
    logic [RW-1:0] sq_ceil;

    assign accept = in_valid && (state_q == IDLE);

    // Sign-extend to N+1 bits so the difference never overflows.
    assign dx = {xd_q[N-1], xd_q} - {xa_q[N-1], xa_q};
    assign dy = {yd_q[N-1], yd_q} - {ya_q[N-1], ya_q};

    // Shift-add squarer: cnt_q walks the multiplier bits of the same magnitude.
    assign mag_sel  = (state_q == SQY) ? magy_q : magx_q;
    assign pp       = mag_sel[cnt_q] ? (HW'(mag_sel) << cnt_q) : '0;
    assign last_bit = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        cnt_d    = cnt_q;
        sq_start = 1'b0;
        case (state_q)
            IDLE: begin
                h_d   = '0;
                cnt_d = '0;
                if (in_valid) state_d = DIFF;
            end
            DIFF: state_d = SQX;
            SQX: begin
                h_d   = h_q + pp;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d = SQY;
                    cnt_d   = '0;
                end
            end
            SQY: begin
                h_d   = h_q + pp;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    // The root unit loads the final H on the same edge we enter SQRT.
                    state_d  = SQRT;
                    cnt_d    = '0;
                    sq_start = 1'b1;
                end
            end
            SQRT: if (sq_done) state_d = FIN;
            FIN:  state_d = HOLD;
            HOLD: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            cnt_q   <= '0;
            xd_q    <= '0;
            yd_q    <= '0;
            xa_q    <= '0;
            ya_q    <= '0;
            magx_q  <= '0;
            magy_q  <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                {xd_q, yd_q} <= g_input;
                {xa_q, ya_q} <= a_xy;
            end
            if (state_q == DIFF) begin
                magx_q <= dx[N] ? N'(-dx) : dx[N-1:0];
                magy_q <= dy[N] ? N'(-dy) : dy[N-1:0];
            end
            if (state_q == FIN) begin
                out_q <= {xa_q, ya_q, sq_ceil};
                sat_q <= sq_sat;
            end
        end
    end

    isqrt_ceil_seq #(
        .W    (2 * N + 2),
        .MAXR (sat_value(N))
    ) u_isqrt (
        .clk     (clk),
        .rst     (rst),
        .start_i (sq_start),
        .rad_i   ({1'b0, h_d}),
        .done_o  (sq_done),
        .ceil_o  (sq_ceil),
        .sat_o   (sq_sat)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign e_output  = out_q;
    assign sat       = sat_q;

`ifdef RANGE_ENCODER_DIST_OUT_EN
    logic [HW-1:0] dist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dist_q <= '0;
        end else if (state_q == FIN) begin
            dist_q <= h_q;
        end
    end

    assign dist_sq = dist_q;
`endif

endmodule

// File: tb/tb_range_encoder.sv
// Purpose: randomized scoreboard bench for range_encoder against an arithmetic radius model.
// Latency: checks that out_valid rises exactly latency(N) cycles after each accept.
// Backpressure: exercises held out_ready, ignored in_valid while busy, and reset mid-computation.
module tb_range_encoder;
    import range_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] g_input;
    logic [15:0] a_xy;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] e_output;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic        man_rdy = 1'b1;
    logic        rnd_rdy = 1'b1;
    bit          rand_rdy = 1'b0;
`ifdef RANGE_ENCODER_DIST_OUT_EN
    logic [16:0] dist_sq;
`endif

    assign out_ready = rand_rdy ? rnd_rdy : man_rdy;

    range_encoder #(.N(DEF_N)) dut (
        .clk       (clk),
        .rst       (rst),
        .g_input   (g_input),
        .a_xy      (a_xy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e_output  (e_output),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RANGE_ENCODER_DIST_OUT_EN
        ,
        .dist_sq   (dist_sq)
`endif
    );

    always #5 clk = ~clk;

    logic [24:0] exp_e_q[$];
    bit          exp_s_q[$];
    logic [16:0] exp_d_q[$];
    int          lat_q[$];
    int          n_pass = 0;
    int          n_chk  = 0;
    int          negcnt = 0;
    bit          prev_vld = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Reference: smallest integer r with r*r >= dx^2 + dy^2, clamped to SAT_VAL.
    function automatic void model(input logic signed [7:0] xd, yd, xa, ya,
                                  output logic [24:0] e, output bit s, output logic [16:0] d);
        int dx, dy, dd, r;
        dx = int'(xd) - int'(xa);
        dy = int'(yd) - int'(ya);
        dd = dx * dx + dy * dy;
        r  = 0;
        while (r * r < dd) r++;
        s = (r > SAT_VAL);
        if (s) r = SAT_VAL;
        e = {xa, ya, 9'(r)};
        d = 17'(dd);
    endfunction

    // Monitor: latency on each rising out_valid, record compare on each transfer.
    always @(negedge clk) begin
        logic [24:0] e;
        bit          s;
        logic [16:0] d;
        negcnt++;
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (out_valid && !prev_vld && lat_q.size() > 0)
                check("latency", negcnt - lat_q[0], latency(DEF_N));
            if (out_valid && out_ready) begin
                if (exp_e_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: got record %0h, expected none pending", e_output);
                end else begin
                    e = exp_e_q.pop_front();
                    s = exp_s_q.pop_front();
                    d = exp_d_q.pop_front();
                    void'(lat_q.pop_front());
                    check("e_output", 32'(e_output), 32'(e));
                    check("sat", 32'(sat), 32'(s));
`ifdef RANGE_ENCODER_DIST_OUT_EN
                    check("dist_sq", 32'(dist_sq), 32'(d));
`endif
                end
            end
            prev_vld = out_valid;
        end
    end

    // Random downstream readiness, used only when rand_rdy is set.
    initial begin
        forever begin
            @(posedge clk);
            #1 rnd_rdy = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic send(input logic signed [7:0] xd, yd, xa, ya);
        logic [24:0] e;
        bit          s;
        logic [16:0] d;
        int          n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        g_input  = {xd, yd};
        a_xy     = {xa, ya};
        in_valid = 1'b1;
        @(posedge clk);
        model(xd, yd, xa, ya, e, s, d);
        exp_e_q.push_back(e);
        exp_s_q.push_back(s);
        exp_d_q.push_back(d);
        lat_q.push_back(negcnt);
        #1;
        in_valid = 1'b0;
        g_input  = 16'($urandom);
        a_xy     = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_e_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_e_q.size(), 0);
    endtask

    function automatic logic signed [7:0] rnd8();
        case ($urandom_range(0, 5))
            0:       return -8'sd128;
            1:       return 8'sd127;
            2:       return 8'sd0;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        in_valid = 1'b0;
        g_input  = '0;
        a_xy     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_e_output", 32'(e_output), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed corners.
        send(8'sd0, 8'sd0, 8'sd3, 8'sd4);       drain();
        send(8'sd0, 8'sd0, 8'sd1, 8'sd1);       drain();
        send(-8'sd128, -8'sd128, 8'sd127, 8'sd127); drain();
        send(8'sd5, -8'sd7, 8'sd5, -8'sd7);     drain();

        // Backpressure: hold the record, offer ignored input while busy.
        man_rdy = 1'b0;
        send(8'sd10, -8'sd20, -8'sd30, 8'sd40);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_wait_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            g_input  = 16'($urandom);
            a_xy     = 16'($urandom);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_e_output", 32'(e_output), 32'(exp_e_q[0]));
            check("bp_sat", 32'(sat), 32'(exp_s_q[0]));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        man_rdy  = 1'b1;
        @(posedge clk);
        #1 man_rdy = 1'b0;
        @(negedge clk);
        check("bp_after_valid", 32'(out_valid), 32'd0);
        check("bp_after_ready", 32'(in_ready), 32'd1);
        man_rdy = 1'b1;
        send(-8'sd100, 8'sd50, 8'sd60, -8'sd70); drain();

        // Reset while squaring dy aborts the record.
        send(8'sd20, 8'sd20, -8'sd50, 8'sd60);
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        exp_e_q.delete();
        exp_s_q.delete();
        exp_d_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_e_output", 32'(e_output), 32'd0);
        check("abort_sat", 32'(sat), 32'd0);
        send(8'sd0, 8'sd0, 8'sd3, 8'sd4); drain();

        // Randomized records with random downstream readiness.
        @(posedge clk);
        #1 rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send(rnd8(), rnd8(), rnd8(), rnd8());
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        drain();
        @(posedge clk);
        #1 rand_rdy = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
